intdiv_sd2_divider: RTL and testbench

INTDIV_SD2_DIVIDER -- requirements
Module: intdiv_sd2_divider

---
 rtl/intdiv_sd2_divider_if.sv | 22 ++
 rtl/intdiv_sd2_divider.sv | 186 ++++++++++++++++++
 tb/tb_intdiv_sd2_divider.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/intdiv_sd2_divider_if.sv
// Handshake and data bundle for the signed SD2 divider.
interface intdiv_sd2_divider_if #(
  parameter int N = 4
);
  logic         in_valid;
  logic [N-1:0] x;
  logic [N-1:0] y;
  logic         out_valid;
  logic [N-1:0] z;
  logic [N-1:0] r;
  logic         div_by_zero;

  modport master (
    output in_valid, x, y,
    input  out_valid, z, r, div_by_zero
  );

  modport slave (
    input  in_valid, x, y,
    output out_valid, z, r, div_by_zero
  );
endinterface

// File: rtl/intdiv_sd2_divider.sv
// Signed N-bit divider: combinational non-restoring array on signed-digit radix-2
// partial remainders, one output register stage. Results follow Verilog "/" and "%".
module intdiv_sd2_divider #(
  parameter int N = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  intdiv_sd2_divider_if.slave bus
);
  // Partial remainders never exceed 2*|y| <= 2^N in magnitude; two extra digits
  // keep that range unambiguous when read back modulo 2^W.
  localparam int W  = N + 2;
  localparam int DW = 2 * W;

  function automatic logic signed [2:0] sd2_val(input logic [1:0] d);
    logic signed [2:0] v;
    case (d)
      2'b00:        v = 3'sb000;
      2'b01, 2'b10: v = 3'sb001;
      2'b11:        v = 3'sb111;
      default:      v = 3'sb000;
    endcase
    return v;
  endfunction

  function automatic logic [1:0] sd2_enc(input logic signed [2:0] v);
    logic [1:0] d;
    case (v)
      3'sb001: d = 2'b01;
      3'sb111: d = 2'b11;
      default: d = 2'b00;
    endcase
    return d;
  endfunction

  // Divisor bit as a digit, negated when the row subtracts.
  function automatic logic signed [2:0] sd2_neg(input logic bbit, input logic sub);
    logic signed [2:0] v;
    if (!bbit) begin
      v = 3'sb000;
    end else if (sub) begin
      v = 3'sb111;
    end else begin
      v = 3'sb001;
    end
    return v;
  endfunction

  // Carry-free SD2 addition of +/-b: each position's transfer is chosen from the
  // sign of the position below, so every output digit stays within {-1,0,+1}.
  function automatic logic [DW-1:0] sd2_add(input logic [DW-1:0] s,
                                            input logic [W-1:0]  bext,
                                            input logic          sub);
    logic signed [2:0] t;
    logic signed [2:0] c;
    logic signed [2:0] w;
    logic signed [2:0] cin;
    logic              lo_nonneg;
    logic [DW-1:0]     res;
    res       = {DW{1'b0}};
    cin       = 3'sb000;
    lo_nonneg = 1'b1;
    for (int k = 0; k < W; k++) begin
      t = sd2_val(s[2*k +: 2]) + sd2_neg(bext[k], sub);
      case (t)
        3'sb010: begin c = 3'sb001; w = 3'sb000; end
        3'sb110: begin c = 3'sb111; w = 3'sb000; end
        3'sb001: begin
          if (lo_nonneg) begin c = 3'sb001; w = 3'sb111; end
          else           begin c = 3'sb000; w = 3'sb001; end
        end
        3'sb111: begin
          if (lo_nonneg) begin c = 3'sb000; w = 3'sb111; end
          else           begin c = 3'sb111; w = 3'sb001; end
        end
        default: begin c = 3'sb000; w = 3'sb000; end
      endcase
      res[2*k +: 2] = sd2_enc(w + cin);
      cin           = c;
      lo_nonneg     = ~t[2];
    end
    return res;
  endfunction

  // Two's-complement value of a digit vector (modulo 2^W).
  function automatic logic [W-1:0] sd2_to_tc(input logic [DW-1:0] p);
    logic [W-1:0] pos;
    logic [W-1:0] neg;
    for (int k = 0; k < W; k++) begin
      pos[k] = (p[2*k +: 2] == 2'b01) || (p[2*k +: 2] == 2'b10);
      neg[k] = (p[2*k +: 2] == 2'b11);
    end
    return pos - neg;
  endfunction

  // N rows on magnitudes; returns {quotient, raw final remainder}. A row's
  // remainder sign equals the restoring remainder's sign, so quotient bits are exact.
  function automatic logic [N+W-1:0] sd2_array(input logic [N-1:0] a,
                                               input logic [N-1:0] b);
    logic [DW-1:0] p;
    logic [W-1:0]  pv;
    logic [N-1:0]  q;
    logic [W-1:0]  bext;
    bext = W'(b);
    p    = {DW{1'b0}};
    pv   = {W{1'b0}};
    q    = {N{1'b0}};
    for (int j = N - 1; j >= 0; j--) begin
      p    = sd2_add({p[DW-3:0], 1'b0, a[j]}, bext, ~pv[W-1]);
      pv   = sd2_to_tc(p);
      q[j] = ~pv[W-1];
    end
    return {q, pv};
  endfunction

  logic         sx_s;
  logic         sy_s;
  logic         dbz_s;
  logic [N-1:0] a_s;
  logic [N-1:0] b_s;
  logic [N-1:0] q_s;
  logic [W-1:0] praw_s;
  logic [N-1:0] rmag_s;
  logic [N-1:0] z_d_s;
  logic [N-1:0] r_d_s;

  logic         out_valid_r;
  logic         dbz_r;
  logic [N-1:0] z_r;
  logic [N-1:0] r_r;

  assign sx_s  = bus.x[N-1];
  assign sy_s  = bus.y[N-1];
  assign dbz_s = (bus.y == {N{1'b0}});
  // -2^(N-1) maps onto itself, which is its correct unsigned magnitude.
  assign a_s   = sx_s ? -bus.x : bus.x;
  assign b_s   = sy_s ? -bus.y : bus.y;

  assign {q_s, praw_s} = sd2_array(a_s, b_s);

  // Correction row: a negative raw remainder (including -|y|) gets |y| added back.
  assign rmag_s = N'(praw_s + (praw_s[W-1] ? W'(b_s) : {W{1'b0}}));

  // Sign restoration of quotient and remainder, with the divide-by-zero override.
  always_comb begin
    z_d_s = {N{1'b0}};
    r_d_s = {N{1'b0}};
    if (dbz_s) begin
      z_d_s = {N{1'b1}};
      r_d_s = bus.x;
    end else begin
      if (sx_s ^ sy_s) begin
        z_d_s = -q_s;
      end else begin
        z_d_s = q_s;
      end
      if (sx_s) begin
        r_d_s = -rmag_s;
      end else begin
        r_d_s = rmag_s;
      end
    end
  end

  // Output register stage; results hold while no new sample arrives.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_r <= 1'b0;
      dbz_r       <= 1'b0;
      z_r         <= {N{1'b0}};
      r_r         <= {N{1'b0}};
    end else begin
      out_valid_r <= bus.in_valid;
      if (bus.in_valid) begin
        dbz_r <= dbz_s;
        z_r   <= z_d_s;
        r_r   <= r_d_s;
      end
    end
  end

  assign bus.out_valid   = out_valid_r;
  assign bus.div_by_zero = dbz_r;
  assign bus.z           = z_r;
  assign bus.r           = r_r;
endmodule

// File: tb/tb_intdiv_sd2_divider.sv
// Self-checking bench for intdiv_sd2_divider (N=4): directed, exhaustive, random
// and reset-interruption stimulus against an arithmetic reference model.
module tb_intdiv_sd2_divider;
  localparam int N = 4;

  typedef struct packed {
    logic         dbz;
    logic [N-1:0] z;
    logic [N-1:0] r;
  } res_t;

  logic clk;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;
  bit   pinned   = 1'b0;

  logic         exp_valid;
  logic         exp_dbz;
  logic [N-1:0] exp_z;
  logic [N-1:0] exp_r;

  intdiv_sd2_divider_if #(.N(N)) bus ();

  intdiv_sd2_divider #(.N(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: signed "/" and "%" on integers, with the divide-by-zero rule.
  function automatic res_t model(input logic [N-1:0] xv, input logic [N-1:0] yv);
    res_t res;
    int   xi;
    int   yi;
    xi = int'($signed(xv));
    yi = int'($signed(yv));
    if (yi == 0) begin
      res.dbz = 1'b1;
      res.z   = {N{1'b1}};
      res.r   = xv;
    end else begin
      res.dbz = 1'b0;
      res.z   = N'(xi / yi);
      res.r   = N'(xi % yi);
    end
    return res;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Expected outputs: a sample taken on an edge shows after that edge; reset clears.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_valid <= 1'b0;
      exp_dbz   <= 1'b0;
      exp_z     <= '0;
      exp_r     <= '0;
    end else begin
      exp_valid <= bus.in_valid;
      if (bus.in_valid) begin
        {exp_dbz, exp_z, exp_r} <= model(bus.x, bus.y);
      end
    end
  end

  // Compare process: away from the rising edge, and 1ns after any reset assertion.
  always begin
    @(negedge clk or negedge rst_n);
    #1;
    if (!pinned) begin
      pinned = 1'b1;
      chk("pin_m2_7",   model(4'b1110, 4'b0111), {1'b0, 4'b0000, 4'b1110});
      chk("pin_m8_m5",  model(4'b1000, 4'b1011), {1'b0, 4'b0001, 4'b1101});
      chk("pin_7_m2",   model(4'b0111, 4'b1110), {1'b0, 4'b1101, 4'b0001});
      chk("pin_m7_2",   model(4'b1001, 4'b0010), {1'b0, 4'b1101, 4'b1111});
      chk("pin_5_0",    model(4'b0101, 4'b0000), {1'b1, 4'b1111, 4'b0101});
      chk("pin_m8_m1",  model(4'b1000, 4'b1111), {1'b0, 4'b1000, 4'b0000});
    end
    if (!rst_n) begin
      chk("rst_out_valid", 32'(bus.out_valid),   32'd0);
      chk("rst_z",         32'(bus.z),           32'd0);
      chk("rst_r",         32'(bus.r),           32'd0);
      chk("rst_dbz",       32'(bus.div_by_zero), 32'd0);
    end else begin
      chk("out_valid", 32'(bus.out_valid), 32'(exp_valid));
      chk(exp_valid ? "z" : "z_hold", 32'(bus.z), 32'(exp_z));
      chk(exp_valid ? "r" : "r_hold", 32'(bus.r), 32'(exp_r));
      chk(exp_valid ? "dbz" : "dbz_hold", 32'(bus.div_by_zero), 32'(exp_dbz));
    end
  end

  task automatic drive(input logic v, input logic [N-1:0] xv, input logic [N-1:0] yv);
    @(negedge clk);
    bus.in_valid = v;
    bus.x        = xv;
    bus.y        = yv;
  endtask

  initial begin
    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    bus.x        = '0;
    bus.y        = '0;
    @(negedge clk);
    @(negedge clk);
    // First operation is presented before release and must be taken on the next edge.
    bus.in_valid = 1'b1;
    bus.x        = 4'b1110;
    bus.y        = 4'b0111;
    #2 rst_n = 1'b1;

    drive(1'b1, 4'b1000, 4'b1011);
    drive(1'b1, 4'b0111, 4'b1110);
    drive(1'b0, 4'b0011, 4'b0011);
    drive(1'b1, 4'b1001, 4'b0010);
    drive(1'b1, 4'b0101, 4'b0000);
    drive(1'b1, 4'b1000, 4'b1111);
    drive(1'b0, 4'b0001, 4'b0001);
    drive(1'b0, 4'b0010, 4'b0000);

    for (int xi = 0; xi < 16; xi++) begin
      for (int yi = 1; yi < 16; yi++) begin
        drive(1'b1, 4'(xi), 4'(yi));
      end
    end

    for (int n = 0; n < 400; n++) begin
      drive(($urandom_range(3, 0) != 0), 4'($urandom), 4'($urandom_range(15, 0)));
    end

    // Reset between two valid samples: the second must never surface.
    drive(1'b1, 4'b0111, 4'b0010);
    drive(1'b1, 4'b1011, 4'b0011);
    #2 rst_n = 1'b0;
    @(negedge clk);
    bus.in_valid = 1'b0;
    #2 rst_n = 1'b1;
    drive(1'b0, 4'b0100, 4'b0001);
    drive(1'b1, 4'b0110, 4'b1100);
    drive(1'b0, 4'b0000, 4'b0000);
    drive(1'b0, 4'b0000, 4'b0000);
    @(negedge clk);
    #3;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
